// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour in, timing/colour out.
// The master (timing generator) drives timing and rgb_out; the slave (pixel generator/DAC side) drives rgb_in.
interface vga_timing_gen_if #(
  parameter int COLOR_W = 10,
  parameter int CNT_W   = 10
);
  logic [3*COLOR_W-1:0] rgb_in;
  logic                 p_tick;
  logic [CNT_W-1:0]     x;
  logic [CNT_W-1:0]     y;
  logic                 video_on;
  logic                 frame_end;
  logic                 hsync;
  logic                 vsync;
  logic                 blank_n;
  logic [3*COLOR_W-1:0] rgb_out;

  modport master (
    input  rgb_in,
    output p_tick, x, y, video_on, frame_end, hsync, vsync, blank_n, rgb_out
  );

  modport slave (
    output rgb_in,
    input  p_tick, x, y, video_on, frame_end, hsync, vsync, blank_n, rgb_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters and a
// one-pixel output pipeline that keeps colour, syncs and blank_n aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 10
) (
  input logic             clk_50MHz,
  input logic             reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Region bounds are compared at 32 bits so a zero back porch cannot overflow CNT_W.
  localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]     divCnt_q, divCnt_d;
  logic [CNT_W-1:0]     hCnt_q, hCnt_d;
  logic [CNT_W-1:0]     vCnt_q, vCnt_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 blank_q, blank_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;

  logic        pTick, hLast, vLast, videoOn, hsRaw, vsRaw;
  logic [31:0] hCnt32, vCnt32;

  always_comb begin
    hCnt32  = 32'(hCnt_q);
    vCnt32  = 32'(vCnt_q);
    pTick   = (divCnt_q == DIV_LAST);
    hLast   = (hCnt_q == H_LAST);
    vLast   = (vCnt_q == V_LAST);
    videoOn = (hCnt32 < H_ACT_END) && (vCnt32 < V_ACT_END);
    hsRaw   = (hCnt32 >= H_SYNC_BEG) && (hCnt32 < H_SYNC_END);
    vsRaw   = (vCnt32 >= V_SYNC_BEG) && (vCnt32 < V_SYNC_END);
  end

  // Everything except the divider holds between pixel ticks.
  always_comb begin
    divCnt_d = pTick ? '0 : divCnt_q + DIV_W'(1);
    hCnt_d   = hCnt_q;
    vCnt_d   = vCnt_q;
    rgb_d    = rgb_q;
    blank_d  = blank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (pTick) begin
      if (hLast) begin
        hCnt_d = '0;
        vCnt_d = vLast ? '0 : vCnt_q + CNT_W'(1);
      end else begin
        hCnt_d = hCnt_q + CNT_W'(1);
      end
      rgb_d   = videoOn ? vga.rgb_in : '0;
      blank_d = videoOn;
      hsync_d = hsRaw ? HS_POL : ~HS_POL;
      vsync_d = vsRaw ? VS_POL : ~VS_POL;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      divCnt_q <= '0;
      hCnt_q   <= '0;
      vCnt_q   <= '0;
      rgb_q    <= '0;
      blank_q  <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
    end else begin
      divCnt_q <= divCnt_d;
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
      rgb_q    <= rgb_d;
      blank_q  <= blank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign vga.p_tick    = pTick;
  assign vga.x         = hCnt_q;
  assign vga.y         = vCnt_q;
  assign vga.video_on  = videoOn;
  assign vga.frame_end = pTick && hLast && vLast;
  assign vga.rgb_out   = rgb_q;
  assign vga.blank_n   = blank_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives three timing configurations side by side with random colour and resets,
// checking every output each clock against an arithmetic model of the raster.
module tb_vga_timing_gen;
  localparam int NCYC = 20000;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, div;
    bit hpol, vpol;
  } cfg_t;

  typedef struct packed {
    int x, y;
    bit vid, tick, fe, hsAct, vsAct;
  } pix_t;

  typedef struct packed {
    logic [31:0] x, y;
    logic vid, tick, fe, hs, vs, bn;
    logic [29:0] rgb;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst   [3];
  logic [29:0] rgbIn [3];
  obs_t        obs   [3];

  cfg_t        cfg    [3];
  string       nm     [3];
  int          kCnt   [3];
  logic [29:0] pRgb   [3];
  bit          pBlank [3];
  bit          pHs    [3];
  bit          pVs    [3];
  bit          started[3];

  int compareCnt  = 0;
  int mismatchCnt = 0;
  int hsLowLen    = 0;
  bit allOnes     = 1'b0;

  vga_timing_gen_if #(.COLOR_W(10), .CNT_W(10)) ifA ();
  vga_timing_gen_if #(.COLOR_W(10), .CNT_W(3))  ifB ();
  vga_timing_gen_if #(.COLOR_W(10), .CNT_W(4))  ifC ();

  vga_timing_gen dutA (.clk_50MHz(clock), .reset(rst[0]), .vga(ifA.master));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(10), .CNT_W(3)
  ) dutB (.clk_50MHz(clock), .reset(rst[1]), .vga(ifB.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(10), .CNT_W(4)
  ) dutC (.clk_50MHz(clock), .reset(rst[2]), .vga(ifC.master));

  assign ifA.rgb_in = rgbIn[0];
  assign ifB.rgb_in = rgbIn[1];
  assign ifC.rgb_in = rgbIn[2];

  assign obs[0] = {32'(ifA.x), 32'(ifA.y), ifA.video_on, ifA.p_tick, ifA.frame_end,
                   ifA.hsync, ifA.vsync, ifA.blank_n, ifA.rgb_out};
  assign obs[1] = {32'(ifB.x), 32'(ifB.y), ifB.video_on, ifB.p_tick, ifB.frame_end,
                   ifB.hsync, ifB.vsync, ifB.blank_n, ifB.rgb_out};
  assign obs[2] = {32'(ifC.x), 32'(ifC.y), ifC.video_on, ifC.p_tick, ifC.frame_end,
                   ifC.hsync, ifC.vsync, ifC.blank_n, ifC.rgb_out};

  // Raster position after k clocks since reset: n = k/div pixels have elapsed.
  function automatic pix_t pixelAt(input cfg_t c, input int k);
    pix_t p;
    int ht, vt, n;
    ht      = c.ha + c.hf + c.hs + c.hb;
    vt      = c.va + c.vf + c.vs + c.vb;
    n       = k / c.div;
    p.x     = n % ht;
    p.y     = (n / ht) % vt;
    p.tick  = (k % c.div) == (c.div - 1);
    p.vid   = (p.x < c.ha) && (p.y < c.va);
    p.hsAct = (p.x >= c.ha + c.hf) && (p.x < c.ha + c.hf + c.hs);
    p.vsAct = (p.y >= c.va + c.vf) && (p.y < c.va + c.vf + c.vs);
    p.fe    = p.tick && (p.x == ht - 1) && (p.y == vt - 1);
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelEdge(input int i);
    pix_t p;
    if (rst[i]) begin
      started[i] = 1'b1;
      kCnt[i]    = 0;
      pRgb[i]    = '0;
      pBlank[i]  = 1'b0;
      pHs[i]     = ~cfg[i].hpol;
      pVs[i]     = ~cfg[i].vpol;
      if (i == 0) hsLowLen = 0;
    end else if (started[i]) begin
      p = pixelAt(cfg[i], kCnt[i]);
      if (p.tick) begin
        pRgb[i]   = p.vid ? rgbIn[i] : '0;
        pBlank[i] = p.vid;
        pHs[i]    = p.hsAct ? cfg[i].hpol : ~cfg[i].hpol;
        pVs[i]    = p.vsAct ? cfg[i].vpol : ~cfg[i].vpol;
      end
      kCnt[i]++;
    end
  endtask

  task automatic compareAll(input int i);
    pix_t p;
    obs_t o;
    p = pixelAt(cfg[i], kCnt[i]);
    o = obs[i];
    checkOutput({nm[i], ".x"},         o.x,          32'(p.x));
    checkOutput({nm[i], ".y"},         o.y,          32'(p.y));
    checkOutput({nm[i], ".video_on"},  32'(o.vid),   32'(p.vid));
    checkOutput({nm[i], ".p_tick"},    32'(o.tick),  32'(p.tick));
    checkOutput({nm[i], ".frame_end"}, 32'(o.fe),    32'(p.fe));
    checkOutput({nm[i], ".hsync"},     32'(o.hs),    32'(pHs[i]));
    checkOutput({nm[i], ".vsync"},     32'(o.vs),    32'(pVs[i]));
    checkOutput({nm[i], ".blank_n"},   32'(o.bn),    32'(pBlank[i]));
    checkOutput({nm[i], ".rgb_out"},   32'(o.rgb),   32'(pRgb[i]));
  endtask

  // Random colour (with an all-ones window for blanking edges) and sparse random resets.
  task automatic applyStimulus(input int cyc);
    allOnes = (cyc >= 4000) && (cyc < 9000);
    for (int i = 0; i < 3; i++) begin
      rgbIn[i] = allOnes ? 30'h3FFFFFFF : 30'($urandom);
      if (cyc < 2)
        rst[i] = 1'b1;
      else if (i == 0)
        rst[i] = (cyc == 9001) || ($urandom_range(0, 5999) == 0);
      else
        rst[i] = ($urandom_range(0, 399) == 0);
    end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
    cfg[1] = '{4, 1, 1, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1};
    cfg[2] = '{8, 2, 3, 2, 5, 1, 2, 1, 3, 1'b0, 1'b1};
    nm[0] = "A";
    nm[1] = "B";
    nm[2] = "C";
    for (int i = 0; i < 3; i++) begin
      started[i] = 1'b0;
      kCnt[i]    = 0;
    end
    applyStimulus(0);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clock);
      for (int i = 0; i < 3; i++) modelEdge(i);
      @(negedge clock);
      for (int i = 0; i < 3; i++)
        if (started[i]) compareAll(i);
      // An uninterrupted default-timing hsync pulse lasts 96 pixels of 2 clocks.
      if (started[0]) begin
        if (ifA.hsync === 1'b0)
          hsLowLen++;
        else if (hsLowLen > 0) begin
          checkOutput("A.hsLowLen", 32'(hsLowLen), 32'd192);
          hsLowLen = 0;
        end
      end
      applyStimulus(cyc + 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end
endmodule
